// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, memory, ALU, JAL and BEQ steps.
// Outputs are decoded combinationally from the current state and a few live inputs.
module riscv_multicycle_ctrl #(
   parameter int BW_OPCODE = 7
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [BW_OPCODE-1:0] i_opcode,
   input  logic [2:0]           i_funct3,
   input  logic                 i_zero,
   input  logic                 i_mem_ready,
   output logic                 o_mem_req,
   output logic                 o_mem_we,
   output logic                 o_pc_en,
   output logic                 o_ir_en,
   output logic                 o_reg_we,
   output logic                 o_addr_src,
   output logic [1:0]           o_alu_src_a,
   output logic [1:0]           o_alu_src_b,
   output logic [1:0]           o_alu_op,
   output logic [1:0]           o_result_src,
   output logic                 o_illegal,
   output logic [3:0]           o_state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [BW_OPCODE-1:0] OP_LOAD   = BW_OPCODE'(7'b0000011);
   localparam logic [BW_OPCODE-1:0] OP_STORE  = BW_OPCODE'(7'b0100011);
   localparam logic [BW_OPCODE-1:0] OP_RTYPE  = BW_OPCODE'(7'b0110011);
   localparam logic [BW_OPCODE-1:0] OP_ITYPE  = BW_OPCODE'(7'b0010011);
   localparam logic [BW_OPCODE-1:0] OP_JAL    = BW_OPCODE'(7'b1101111);
   localparam logic [BW_OPCODE-1:0] OP_BRANCH = BW_OPCODE'(7'b1100011);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory handshake: o_mem_req is valid, i_mem_ready is ready; a transfer completes
   // in a cycle where both are 1. Until then state and all outputs hold unchanged.
   always_comb begin
      state_d      = S_FETCH;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_pc_en      = 1'b0;
      o_ir_en      = 1'b0;
      o_reg_we     = 1'b0;
      o_addr_src   = 1'b0;
      o_alu_src_a  = 2'd0;
      o_alu_src_b  = 2'd0;
      o_alu_op     = 2'd0;
      o_result_src = 2'd0;
      o_illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            o_mem_req    = 1'b1;
            o_alu_src_b  = 2'd2;
            o_result_src = 2'd2;
            o_ir_en      = i_mem_ready;
            o_pc_en      = i_mem_ready;
            state_d      = i_mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            o_alu_src_a = 2'd1;
            o_alu_src_b = 2'd1;
            if (i_opcode == OP_LOAD || i_opcode == OP_STORE) begin
               state_d = S_MEMADR;
            end else if (i_opcode == OP_RTYPE) begin
               state_d = S_EXECR;
            end else if (i_opcode == OP_ITYPE) begin
               state_d = S_EXECI;
            end else if (i_opcode == OP_JAL) begin
               state_d = S_JAL;
            end else if (i_opcode == OP_BRANCH && i_funct3 == 3'b000) begin
               state_d = S_BEQ;
            end else begin
               o_illegal = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_MEMADR: begin
            o_alu_src_a = 2'd2;
            o_alu_src_b = 2'd1;
            state_d     = (i_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            o_mem_req  = 1'b1;
            o_addr_src = 1'b1;
            state_d    = i_mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            o_reg_we     = 1'b1;
            o_result_src = 2'd1;
         end
         S_MEMWRITE: begin
            o_mem_req  = 1'b1;
            o_mem_we   = 1'b1;
            o_addr_src = 1'b1;
            state_d    = i_mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            o_alu_src_a = 2'd2;
            o_alu_op    = 2'd2;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            o_alu_src_a = 2'd2;
            o_alu_src_b = 2'd1;
            o_alu_op    = 2'd2;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            o_reg_we = 1'b1;
         end
         S_JAL: begin
            o_alu_src_a = 2'd1;
            o_alu_src_b = 2'd2;
            o_pc_en     = 1'b1;
            state_d     = S_ALUWB;
         end
         S_BEQ: begin
            o_alu_src_a = 2'd2;
            o_alu_op    = 2'd1;
            o_pc_en     = i_zero;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset kills every strobe immediately so an abandoned instruction writes nothing.
      if (!i_rstn) begin
         o_mem_req = 1'b0;
         o_mem_we  = 1'b0;
         o_pc_en   = 1'b0;
         o_ir_en   = 1'b0;
         o_reg_we  = 1'b0;
         o_illegal = 1'b0;
      end
   end

   assign o_state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: directed instruction table, reset corner cases,
// then random instructions and ready stalls checked against an instruction-level model.
module tb_riscv_multicycle_ctrl;

   logic       i_clk;
   logic       i_rstn;
   logic [6:0] i_opcode;
   logic [2:0] i_funct3;
   logic       i_zero;
   logic       i_mem_ready;
   logic       o_mem_req;
   logic       o_mem_we;
   logic       o_pc_en;
   logic       o_ir_en;
   logic       o_reg_we;
   logic       o_addr_src;
   logic [1:0] o_alu_src_a;
   logic [1:0] o_alu_src_b;
   logic [1:0] o_alu_op;
   logic [1:0] o_result_src;
   logic       o_illegal;
   logic [3:0] o_state;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [14:0] RST_MASK = 15'h01FF;

   riscv_multicycle_ctrl #(.BW_OPCODE(7)) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_opcode     (i_opcode),
      .i_funct3     (i_funct3),
      .i_zero       (i_zero),
      .i_mem_ready  (i_mem_ready),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_pc_en      (o_pc_en),
      .o_ir_en      (o_ir_en),
      .o_reg_we     (o_reg_we),
      .o_addr_src   (o_addr_src),
      .o_alu_src_a  (o_alu_src_a),
      .o_alu_src_b  (o_alu_src_b),
      .o_alu_op     (o_alu_op),
      .o_result_src (o_result_src),
      .o_illegal    (o_illegal),
      .o_state      (o_state)
   );

   // clock / watchdog
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not reach the summary, act=timeout req=finish");
      $fatal(1);
   end

   // Expected control word {mem_req,mem_we,pc_en,ir_en,reg_we,illegal,addr_src,src_a,src_b,alu_op,result_src}
   function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                            input logic z, input logic ill);
      logic mr, mw, pe, ie, rw, il, as;
      logic [1:0] sa, sb, ao, rs;
      {mr, mw, pe, ie, rw, il, as} = 7'd0;
      {sa, sb, ao, rs} = 8'd0;
      case (st)
         4'd0:  begin mr = 1; sb = 2; rs = 2; pe = rdy; ie = rdy; end
         4'd1:  begin sa = 1; sb = 1; il = ill; end
         4'd2:  begin sa = 2; sb = 1; end
         4'd3:  begin mr = 1; as = 1; end
         4'd4:  begin rw = 1; rs = 1; end
         4'd5:  begin mr = 1; mw = 1; as = 1; end
         4'd6:  begin sa = 2; ao = 2; end
         4'd7:  begin rw = 1; end
         4'd8:  begin sa = 2; sb = 1; ao = 2; end
         4'd9:  begin sa = 1; sb = 2; pe = 1; end
         4'd10: begin sa = 2; ao = 1; pe = z; end
         default: ;
      endcase
      return {mr, mw, pe, ie, rw, il, as, sa, sb, ao, rs};
   endfunction

   // scoreboard compare
   task automatic check(input logic [3:0] es, input logic [14:0] ec, input string tag);
      logic [14:0] act;
      act = {o_mem_req, o_mem_we, o_pc_en, o_ir_en, o_reg_we, o_illegal, o_addr_src,
             o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src};
      n_checks++;
      if (o_state !== es) begin
         n_fail++;
         $display("FAIL %s state: act=%0d req=%0d", tag, o_state, es);
      end
      n_checks++;
      if (act !== ec) begin
         n_fail++;
         $display("FAIL %s ctrl: act=%h req=%h (state %0d)", tag, act, ec, es);
      end
      n_checks++;
      if (o_mem_we === 1'b1 && o_reg_we === 1'b1) begin
         n_fail++;
         $display("FAIL %s excl: act=mem_we&reg_we req=not both", tag);
      end
   endtask

   // directed table: path nibbles low-first, waits = not-ready cycles in memory states
   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        z;
      int          waits;
      int          len;
      logic [23:0] path;
      string       name;
   } vec_t;

   vec_t vecs[10];

   task automatic set_vec(input int i, input logic [6:0] op, input logic [2:0] f3, input logic z,
                          input int waits, input int len, input logic [23:0] path, input string name);
      vecs[i].op    = op;
      vecs[i].f3    = f3;
      vecs[i].z     = z;
      vecs[i].waits = waits;
      vecs[i].len   = len;
      vecs[i].path  = path;
      vecs[i].name  = name;
   endtask

   task automatic run_vec(input vec_t v);
      logic [3:0] st;
      int w;
      for (int k = 0; k < v.len; k++) begin
         st = v.path[k*4 +: 4];
         w  = (st == 4'd3 || st == 4'd5) ? v.waits : 0;
         for (int j = 0; j <= w; j++) begin
            i_opcode    = v.op;
            i_funct3    = v.f3;
            i_zero      = v.z;
            i_mem_ready = (j == w);
            #1;
            check(st, exp_ctrl(st, i_mem_ready, v.z, v.len == 2), v.name);
            @(negedge i_clk);
         end
      end
   endtask

   // instruction-level model: which steps each instruction class walks through
   logic [3:0] exp_q[$];

   task automatic load_path(input logic [6:0] op, input logic [2:0] f3);
      exp_q = '{};
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd1);
      if (op == 7'b0000011) begin
         exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4);
      end else if (op == 7'b0100011) begin
         exp_q.push_back(4'd2); exp_q.push_back(4'd5);
      end else if (op == 7'b0110011) begin
         exp_q.push_back(4'd6); exp_q.push_back(4'd7);
      end else if (op == 7'b0010011) begin
         exp_q.push_back(4'd8); exp_q.push_back(4'd7);
      end else if (op == 7'b1101111) begin
         exp_q.push_back(4'd9); exp_q.push_back(4'd7);
      end else if (op == 7'b1100011 && f3 == 3'b000) begin
         exp_q.push_back(4'd10);
      end
   endtask

   initial begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [3:0] st;
      logic       ill;
      int         pick;

      set_vec(0, 7'b0000011, 3'd2, 1'b0, 0, 5, 24'h043210, "lw");
      set_vec(1, 7'b0100011, 3'd2, 1'b0, 3, 4, 24'h005210, "sw_wait3");
      set_vec(2, 7'b1100011, 3'd0, 1'b1, 0, 3, 24'h000A10, "beq_taken");
      set_vec(3, 7'b1100011, 3'd0, 1'b0, 0, 3, 24'h000A10, "beq_not_taken");
      set_vec(4, 7'b1101111, 3'd0, 1'b0, 0, 4, 24'h007910, "jal");
      set_vec(5, 7'b0110011, 3'd0, 1'b0, 0, 4, 24'h007610, "rtype");
      set_vec(6, 7'b0010011, 3'd0, 1'b0, 0, 4, 24'h007810, "itype");
      set_vec(7, 7'b0000000, 3'd0, 1'b0, 0, 2, 24'h000010, "illegal_op0");
      set_vec(8, 7'b1100011, 3'd1, 1'b1, 0, 2, 24'h000010, "illegal_bne");
      set_vec(9, 7'b0000011, 3'd2, 1'b0, 2, 5, 24'h043210, "lw_wait2");

      // reset
      i_rstn      = 1'b0;
      i_opcode    = 7'd0;
      i_funct3    = 3'd0;
      i_zero      = 1'b0;
      i_mem_ready = 1'b1;
      @(negedge i_clk);
      #1 check(4'd0, exp_ctrl(4'd0, 1'b1, 1'b0, 1'b0) & RST_MASK, "reset_hold");
      @(negedge i_clk);
      i_rstn = 1'b1;

      // driver: directed table
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // reset while MEMREAD is stalled
      i_opcode = 7'b0000011; i_funct3 = 3'd2; i_mem_ready = 1'b1;
      #1 check(4'd0, exp_ctrl(4'd0, 1'b1, 1'b0, 1'b0), "rst_mid_fetch");
      @(negedge i_clk);
      #1 check(4'd1, exp_ctrl(4'd1, 1'b1, 1'b0, 1'b0), "rst_mid_decode");
      @(negedge i_clk);
      #1 check(4'd2, exp_ctrl(4'd2, 1'b1, 1'b0, 1'b0), "rst_mid_memadr");
      @(negedge i_clk);
      i_mem_ready = 1'b0;
      #1 check(4'd3, exp_ctrl(4'd3, 1'b0, 1'b0, 1'b0), "rst_mid_wait");
      @(negedge i_clk);
      i_rstn = 1'b0;
      #1 check(4'd3, exp_ctrl(4'd3, 1'b0, 1'b0, 1'b0) & RST_MASK, "rst_mid_assert");
      @(negedge i_clk);
      i_mem_ready = 1'b1;
      #1 check(4'd0, exp_ctrl(4'd0, 1'b1, 1'b0, 1'b0) & RST_MASK, "rst_mid_held1");
      @(negedge i_clk);
      #1 check(4'd0, exp_ctrl(4'd0, 1'b1, 1'b0, 1'b0) & RST_MASK, "rst_mid_held2");
      @(negedge i_clk);
      i_rstn = 1'b1;
      run_vec(vecs[0]);

      // random instructions with random ready stalls
      for (int n = 0; n < 300; n++) begin
         pick = $urandom_range(0, 7);
         case (pick)
            0:       op = 7'b0000011;
            1:       op = 7'b0100011;
            2:       op = 7'b0110011;
            3:       op = 7'b0010011;
            4:       op = 7'b1101111;
            5, 6:    op = 7'b1100011;
            default: op = 7'($urandom_range(0, 127));
         endcase
         f3 = (pick == 5) ? 3'd0 : 3'($urandom_range(0, 7));
         load_path(op, f3);
         ill = (exp_q.size() == 2);
         while (exp_q.size() > 0) begin
            st          = exp_q[0];
            i_opcode    = op;
            i_funct3    = f3;
            i_zero      = 1'($urandom_range(0, 1));
            i_mem_ready = ($urandom_range(0, 3) != 0);
            #1 check(st, exp_ctrl(st, i_mem_ready, i_zero, ill), "random");
            if (!(st == 4'd0 || st == 4'd3 || st == 4'd5) || i_mem_ready) void'(exp_q.pop_front());
            @(negedge i_clk);
         end
      end

      // report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_ctrl.md
RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

Interface
REQ-001 Parameter BW_OPCODE, default 7: opcode width; other widths fixed as listed.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_rstn  input  1  reset; synchronous, active-low.
REQ-004 i_opcode  input  BW_OPCODE  opcode from instruction register.
REQ-005 i_funct3  input  3  funct3 from instruction register.
REQ-006 i_zero  input  1  ALU zero flag.
REQ-007 i_mem_ready  input  1  memory accepts/completes current request this cycle.
REQ-008 o_mem_req  output  1  memory request.
REQ-009 o_mem_we  output  1  memory write strobe.
REQ-010 o_pc_en  output  1  enable for PC register.
REQ-011 o_ir_en  output  1  enable for IR and old-PC registers.
REQ-012 o_reg_we  output  1  register-file write enable.
REQ-013 o_addr_src  output  1  0 = PC, 1 = ALUOut.
REQ-014 o_alu_src_a  output  2  0 = PC, 1 = old PC, 2 = rs1.
REQ-015 o_alu_src_b  output  2  0 = rs2, 1 = immediate, 2 = constant 4.
REQ-016 o_alu_op  output  2  0 = add, 1 = sub, 2 = decode funct.
REQ-017 o_result_src  output  2  0 = ALUOut, 1 = memory data, 2 = ALU result.
REQ-018 o_illegal  output  1  one-cycle pulse on unsupported instruction.
REQ-019 o_state  output  4  current state encoding, for debug.

Function
REQ-020 The FSM SHALL use the states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-021 Outputs SHALL be combinational from the state and the listed inputs; unlisted outputs SHALL be 0 in each state.
REQ-022 FETCH: mem_req=1, addr_src=0, src_a=0, src_b=2, alu_op=0, result_src=2; ir_en=pc_en=i_mem_ready; stay in FETCH until i_mem_ready=1, then go to DECODE.
REQ-023 DECODE: src_a=1, src_b=1, alu_op=0 (branch/jump target into ALUOut).
REQ-024 DECODE transitions: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 with funct3=000 -> BEQ; any other opcode/funct3 -> FETCH with o_illegal=1 for that cycle.
REQ-025 MEMADR: src_a=2, src_b=1, alu_op=0; go to MEMREAD if opcode=0000011, else MEMWRITE.
REQ-026 MEMREAD: mem_req=1, addr_src=1; hold until i_mem_ready=1, then go to MEMWB.
REQ-027 MEMWB: reg_we=1, result_src=1; go to FETCH.
REQ-028 MEMWRITE: mem_req=1, mem_we=1, addr_src=1; hold until i_mem_ready=1, then go to FETCH.
REQ-029 EXECR: src_a=2, src_b=0, alu_op=2; EXECI: src_a=2, src_b=1, alu_op=2; both go to ALUWB.
REQ-030 ALUWB: reg_we=1, result_src=0; go to FETCH.
REQ-031 JAL: src_a=1, src_b=2, alu_op=0, result_src=0, pc_en=1; go to ALUWB.
REQ-032 BEQ: src_a=2, src_b=0, alu_op=1, result_src=0, pc_en=i_zero; go to FETCH.
REQ-033 o_mem_we and o_reg_we SHALL never be 1 in the same cycle, and neither SHALL be 1 in any cycle where o_pc_en=1 outside FETCH/JAL/BEQ.
REQ-034 Wait states SHALL be unbounded; every output SHALL stay stable while waiting for i_mem_ready.

Reset
REQ-035 On a rising edge with i_rstn=0, the state SHALL become FETCH.
REQ-036 While i_rstn=0, o_mem_req, o_mem_we, o_pc_en, o_ir_en, o_reg_we and o_illegal SHALL be forced to 0 combinationally.
REQ-037 A reset asserted mid-instruction, including during a wait state, SHALL abandon the instruction with no further write strobes.

Verification
REQ-038 Reset release, i_mem_ready=1, lw (0000011): states 0,1,2,3,4,0; reg_we=1 only in MEMWB; pc_en=ir_en=1 only in the FETCH cycle.
REQ-039 sw (0100011), i_mem_ready low for 3 cycles in MEMWRITE: MEMWRITE held 4 cycles with mem_we=1 throughout; then FETCH; reg_we stays 0.
REQ-040 beq (1100011, funct3=000): with i_zero=1, pc_en=1 in BEQ; repeat with i_zero=0, pc_en=0; both return to FETCH.
REQ-041 jal (1101111): sequence 0,1,9,7,0; pc_en=1 in JAL; reg_we=1 in ALUWB.
REQ-042 Opcode 0000000, then beq with funct3=001: o_illegal pulses 1 cycle in DECODE each time; next state FETCH; no write strobes.
REQ-043 i_rstn=0 while in MEMREAD waiting: next state FETCH; all strobes 0 while reset is held; normal fetch resumes after release.
